// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel registered stream multiplexer with round-robin or manual select
//
// Purpose:
//   Picks one of NCH valid/ready input streams, either by round-robin
//   arbitration or by an explicit channel index, and forwards the chosen beat
//   through a single output register. This gives 1-cycle latency and allows
//   1 beat/cycle sustained throughput.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous, active-high reset
//   in_valid   - per-channel valid, bit i = channel i
//   in_data    - channel i data at [i*WIDTH +: WIDTH]
//   in_ready   - per-channel accept strobe (combinational, at most one bit set)
//   mode       - 0 = round-robin, 1 = manual select
//   sel        - channel index used when mode = 1
//   out_valid  - output register holds a beat
//   out_data   - registered data
//   out_chan   - source channel of out_data
//   out_ready  - consumer accepts the beat when out_valid && out_ready

module stream_mux_rr #(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  localparam int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  input  logic                 out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_chan_q,  out_chan_d;
  logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

  logic             load_en;
  logic             grant_valid;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;

  // The output register can take a new beat when it is empty or being drained.
  assign load_en = !out_valid_q || out_ready;

  // Arbitration. The round-robin scan runs from the far end back towards
  // rr_ptr so the channel closest to rr_ptr overwrites all others.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (mode) begin
      // Manual: a sel outside 0..NCH-1 matches no channel and never grants.
      for (int i = 0; i < NCH; i++) begin
        if (int'(sel) == i && in_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SELW'(i);
        end
      end
    end else begin
      for (int k = NCH - 1; k >= 0; k--) begin
        if (in_valid[(int'(rr_ptr_q) + k) % NCH]) begin
          grant_valid = 1'b1;
          grant_idx   = SELW'((int'(rr_ptr_q) + k) % NCH);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_idx == SELW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    if (load_en && grant_valid) in_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      // Drained with nothing new -> empty; otherwise load the granted beat.
      out_valid_d = grant_valid;
      if (grant_valid) begin
        out_data_d = grant_data;
        out_chan_d = grant_idx;
        // The pointer only tracks round-robin transfers.
        if (!mode) begin
          rr_ptr_d = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + SELW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - randomized and directed bench for stream_mux_rr against a behavioural model
module tb_stream_mux_rr;
  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_chan;
  logic                 out_ready;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit         m_valid;
  logic [7:0] m_data;
  int         m_chan;
  int         m_ptr;

  stream_mux_rr #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_valid(out_valid), .out_data(out_data),
    .out_chan(out_chan), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Channel the rules pick this cycle, -1 for none.
  function automatic int model_grant();
    if (mode) begin
      if (int'(sel) < NCH && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 0; k < NCH; k++) begin
      if (in_valid[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
    end
    return -1;
  endfunction

  function automatic logic [NCH-1:0] model_ready();
    logic [NCH-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if ((!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Advance one clock and update the model from the inputs seen at the edge.
  task automatic tick();
    int g;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = '0; m_chan = 0; m_ptr = 0;
    end else begin
      g = model_grant();
      if (!m_valid || out_ready) begin
        if (g >= 0) begin
          m_valid = 1;
          m_data  = in_data[g*WIDTH +: WIDTH];
          m_chan  = g;
          if (!mode) m_ptr = (g + 1) % NCH;
        end else begin
          m_valid = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic set_rr_data();
    for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = 8'hA0 + 8'(i);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = '0; in_data = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
    m_valid = 0; m_data = '0; m_chan = 0; m_ptr = 0;
    #1;
    total++;
    if ({out_valid, out_data, out_chan} !== '0) begin
      bad++; $display("FAIL reset_initial got v=%b d=%h c=%0d exp 0/00/0", out_valid, out_data, out_chan);
    end
    tick();
    rst = 1'b0;
    in_valid = 4'b0001; in_data[7:0] = 8'h55;
    #1;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h55) begin
      bad++; $display("FAIL reset_load got v=%b d=%h exp 1/55", out_valid, out_data);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({out_valid, out_data, out_chan} !== '0) begin
      bad++; $display("FAIL reset_async got v=%b d=%h c=%0d exp 0/00/0", out_valid, out_data, out_chan);
    end
    tick();
    rst = 1'b0; in_valid = '0;
    #1;
  endtask

  task automatic test_rr_fairness();
    mode = 1'b0; out_ready = 1'b1; in_valid = 4'b1111; set_rr_data();
    #1;
    total++;
    if (in_ready !== 4'b0001) begin
      bad++; $display("FAIL fair_first_ready got %b exp 0001", in_ready);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_chan !== SELW'(c % NCH) || out_data !== 8'hA0 + 8'(c % NCH)) begin
        bad++; $display("FAIL fair_beat%0d got v=%b c=%0d d=%h exp 1/%0d/%h",
                        c, out_valid, out_chan, out_data, c % NCH, 8'hA0 + 8'(c % NCH));
      end
    end
  endtask

  task automatic test_rr_skip();
    in_valid = 4'b0100;
    #1;
    total++;
    if (in_ready !== 4'b0100) begin bad++; $display("FAIL skip_ready_a got %b exp 0100", in_ready); end
    tick();
    in_valid = 4'b1001;
    #1;
    total++;
    if (out_chan !== 2'd2 || in_ready !== 4'b1000) begin
      bad++; $display("FAIL skip_ch2 got c=%0d rdy=%b exp 2/1000", out_chan, in_ready);
    end
    tick();
    #1;
    total++;
    if (out_chan !== 2'd3 || in_ready !== 4'b0001) begin
      bad++; $display("FAIL skip_ch3 got c=%0d rdy=%b exp 3/0001", out_chan, in_ready);
    end
    tick();
    total++;
    if (out_chan !== 2'd0 || out_data !== 8'hA0) begin
      bad++; $display("FAIL skip_ch0 got c=%0d d=%h exp 0/a0", out_chan, out_data);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_manual();
    mode = 1'b1; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (in_ready !== 4'b0100) begin bad++; $display("FAIL manual_ready%0d got %b exp 0100", c, in_ready); end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_chan !== 2'd2 || out_data !== 8'hA2) begin
        bad++; $display("FAIL manual_beat%0d got v=%b c=%0d d=%h exp 1/2/a2", c, out_valid, out_chan, out_data);
      end
    end
    sel = 2'd1; in_valid = 4'b1101;
    #1;
    total++;
    if (in_ready !== 4'b0000) begin bad++; $display("FAIL manual_novalid_ready got %b exp 0000", in_ready); end
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL manual_drop got v=%b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] held_d;
    logic [SELW-1:0]  held_c;
    mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b0;
    tick();
    held_d = out_data; held_c = out_chan;
    total++;
    if (out_valid !== 1'b1 || held_c !== SELW'(m_chan) || held_d !== m_data) begin
      bad++; $display("FAIL bp_load got v=%b c=%0d d=%h exp 1/%0d/%h", out_valid, held_c, held_d, m_chan, m_data);
    end
    for (int c = 0; c < 3; c++) begin
      in_data = {$urandom, $urandom};
      #1;
      total++;
      if (in_ready !== 4'b0000 || out_data !== held_d || out_chan !== held_c) begin
        bad++; $display("FAIL bp_stall%0d got rdy=%b c=%0d d=%h exp 0000/%0d/%h", c, in_ready, out_chan, out_data, held_c, held_d);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== model_ready() || in_ready === 4'b0000) begin
      bad++; $display("FAIL bp_release_ready got %b exp %b", in_ready, model_ready());
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_chan !== SELW'(m_chan) || out_data !== m_data) begin
      bad++; $display("FAIL bp_next_beat got v=%b c=%0d d=%h exp 1/%0d/%h", out_valid, out_chan, out_data, m_chan, m_data);
    end
  endtask

  task automatic test_mode_switch();
    logic [WIDTH-1:0] held_d;
    logic [SELW-1:0]  held_c;
    mode = 1'b0; in_valid = 4'b1111; out_ready = 1'b0;
    tick();
    held_d = out_data; held_c = out_chan;
    mode = 1'b1; sel = 2'd3;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== held_d || out_chan !== held_c) begin
        bad++; $display("FAIL mode_held%0d got v=%b c=%0d d=%h exp 1/%0d/%h", c, out_valid, out_chan, out_data, held_c, held_d);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b1000) begin bad++; $display("FAIL mode_release_ready got %b exp 1000", in_ready); end
    tick();
    total++;
    if (out_chan !== 2'd3 || out_data !== in_data[3*WIDTH +: WIDTH]) begin
      bad++; $display("FAIL mode_new_grant got c=%0d d=%h exp 3", out_chan, out_data);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = NCH'($urandom);
      in_data   = {$urandom, $urandom};
      mode      = ($urandom_range(0, 3) == 0);
      sel       = SELW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      total++;
      if (in_ready !== model_ready()) begin
        bad++; $display("FAIL rand_ready cyc=%0d got %b exp %b", c, in_ready, model_ready());
      end
      total++;
      if (out_valid !== m_valid) begin
        bad++; $display("FAIL rand_valid cyc=%0d got %b exp %b", c, out_valid, m_valid);
      end
      if (m_valid) begin
        total++;
        if (out_chan !== SELW'(m_chan) || out_data !== m_data) begin
          bad++; $display("FAIL rand_beat cyc=%0d got c=%0d d=%h exp %0d/%h", c, out_chan, out_data, m_chan, m_data);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_rr_skip();
    test_manual();
    test_backpressure();
    test_mode_switch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
